// File: rtl/sar_adc_control.sv
// sar_adc_control: successive-approximation ADC sequencer driving an R2R ladder and sampling a comparator
module sar_adc_control #(
  parameter int WIDTH = 8,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             continuous,
  input  logic             comp_in,
  output logic [WIDTH-1:0] dac_out,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             busy
);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] msb = WIDTH'(1) << (WIDTH - 1);
  typedef enum logic [2:0] {IDLE, SET, SETTLE, DECIDE, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] trial, onehot, decided;
  logic [IW-1:0] idx;
  logic [7:0] cnt;
  logic [1:0] sync;
  logic comp_s;
  assign comp_s = sync[1];
  // bit idx of trial is always still clear when DECIDE runs, so OR-ing sets it
  always_comb begin
    onehot = WIDTH'(1) << idx;
    decided = comp_s ? (trial | onehot) : trial;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      dac_out <= '0;
      result <= '0;
      result_valid <= 1'b0;
      busy <= 1'b0;
      trial <= '0;
      idx <= '0;
      cnt <= '0;
      sync <= '0;
    end else begin
      result_valid <= 1'b0;
      sync <= {sync[0], comp_in};
      case (state)
        IDLE: if (start) begin
          trial <= '0;
          idx <= IW'(WIDTH - 1);
          dac_out <= msb;
          busy <= 1'b1;
          state <= SET;
        end
        SET: begin
          cnt <= 8'(SETTLE_CYCLES - 1);
          state <= SETTLE;
        end
        SETTLE: begin
          cnt <= cnt - 8'd1;
          state <= (cnt == 8'd0) ? DECIDE : SETTLE;
        end
        DECIDE: begin
          trial <= decided;
          if (idx != '0) begin
            idx <= idx - IW'(1);
            dac_out <= decided | (onehot >> 1);
            state <= SET;
          end else begin
            result <= decided;
            dac_out <= decided;
            result_valid <= 1'b1;
            state <= DONE;
          end
        end
        DONE: if (continuous) begin
          trial <= '0;
          idx <= IW'(WIDTH - 1);
          dac_out <= msb;
          state <= SET;
        end else begin
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
